// File: rtl/centipede_scandoubler_pkg.sv
// Shared widths, output reset values and start-up states for the Centipede scandoubler.
package centipede_scandoubler_pkg;

    localparam int SD_ADDR_W = 9;
    localparam int SD_PIX_W  = 9;

    // Output values while reset is active or no complete line is stored yet.
    localparam logic RST_RGB    = 1'b0;
    localparam logic RST_HSYNC  = 1'b1;
    localparam logic RST_VSYNC  = 1'b1;
    localparam logic RST_HBLANK = 1'b1;
    localparam logic RST_VBLANK = 1'b1;

    typedef enum logic [1:0] {
        ST_WAIT0,
        ST_WAIT1,
        ST_RUN
    } sd_state_e;

endpackage

// File: rtl/centipede_linebuf.sv
// Two-bank line store: {hblank, rgb} per pixel, one write port, one registered read port.
// Latency: read data valid 1 cycle after rd_addr/rd_bank.
// Backpressure: none; write and read happen every cycle they are requested.
module centipede_linebuf #(
    parameter int ADDR_W = 9,
    parameter int PIX_W  = 9
) (
    input  logic              clk_12mhz,
    input  logic              wr_vld,
    input  logic              wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W:0]    wr_dat,
    input  logic              rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W:0]    rd_dat
);

    logic [PIX_W:0] mem_q [2**(ADDR_W+1)];

    always_ff @(posedge clk_12mhz) begin
        if (wr_vld) begin
            mem_q[{wr_bank, wr_addr}] <= wr_dat;
        end
    end

    always_ff @(posedge clk_12mhz) begin
        rd_dat <= mem_q[{rd_bank, rd_addr}];
    end

endmodule

// File: rtl/centipede_scandoubler.sv
// Line doubler: stores each 6 MHz input line and replays it twice at 12 MHz; en_i=0 is a registered bypass.
// Latency: doubled pixel k appears 2 cycles after out_x = k; bypass is 1 cycle.
// Backpressure: none; free-running video stream, input pixels are never stalled.
module centipede_scandoubler
    import centipede_scandoubler_pkg::*;
#(
    parameter int ADDR_W = SD_ADDR_W,
    parameter int PIX_W  = SD_PIX_W
) (
    input  logic             clk_12mhz,
    input  logic             reset_n,
    input  logic             ce_pix_i,
    input  logic             en_i,
    input  logic [PIX_W-1:0] rgb_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic             hblank_i,
    input  logic             vblank_i,
    output logic [PIX_W-1:0] rgb_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             hblank_o,
    output logic             vblank_o
);

    localparam logic [ADDR_W-1:0] X_MAX = '1;
    localparam logic [ADDR_W-1:0] X_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    sd_state_e         state_q, state_d;
    logic              hs_prev_q, hs_prev_d;
    logic [ADDR_W-1:0] in_x_q, in_x_d;
    logic [ADDR_W-1:0] hs_cnt_q, hs_cnt_d;
    logic [ADDR_W-1:0] line_len_q, line_len_d;
    logic [ADDR_W-1:0] hs_len_q, hs_len_d;
    logic [ADDR_W-1:0] out_x_q, out_x_d;
    logic              wbank_q, wbank_d;
    logic              vs_cap_q, vs_cap_d;
    logic              vb_cap_q, vb_cap_d;
    logic              en_q, en_d;

    logic              s1_vld_q, s1_vld_d;
    logic              s1_first_q, s1_first_d;
    logic              s1_oob_q, s1_oob_d;
    logic              s1_hs_q, s1_hs_d;
    logic              s1_vs_q, s1_vs_d;
    logic              s1_vb_q, s1_vb_d;

    logic [PIX_W-1:0]  rgb_q, rgb_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              hblank_q, hblank_d;
    logic              vblank_q, vblank_d;

    logic              line_start;
    logic              wrap;
    logic              blank;
    logic [ADDR_W-1:0] wr_x;
    logic              wr_vld;
    logic              wr_bank;
    logic [PIX_W:0]    rd_dat;

    centipede_linebuf #(
        .ADDR_W (ADDR_W),
        .PIX_W  (PIX_W)
    ) u_linebuf (
        .clk_12mhz (clk_12mhz),
        .wr_vld    (wr_vld),
        .wr_bank   (wr_bank),
        .wr_addr   (wr_x),
        .wr_dat    ({hblank_i, rgb_i}),
        .rd_bank   (~wbank_q),
        .rd_addr   (out_x_q),
        .rd_dat    (rd_dat)
    );

    // Input side: the line-start pixel is pixel 0 of the new line and lands in the new bank.
    always_comb begin
        line_start = ce_pix_i & hs_prev_q & ~hsync_i;
        wr_x       = line_start ? '0 : in_x_q;
        wr_vld     = ce_pix_i & (wr_x != X_MAX);
        wr_bank    = wbank_q ^ line_start;

        hs_prev_d  = hs_prev_q;
        in_x_d     = in_x_q;
        hs_cnt_d   = hs_cnt_q;
        line_len_d = line_len_q;
        hs_len_d   = hs_len_q;
        wbank_d    = wbank_q;
        vs_cap_d   = vs_cap_q;
        vb_cap_d   = vb_cap_q;
        en_d       = en_q;
        state_d    = state_q;

        if (ce_pix_i) begin
            hs_prev_d = hsync_i;
            in_x_d    = (wr_x == X_MAX) ? X_MAX : wr_x + X_ONE;
            if (line_start) begin
                hs_cnt_d = X_ONE;
            end else if (!hsync_i && hs_cnt_q != X_MAX) begin
                hs_cnt_d = hs_cnt_q + X_ONE;
            end
        end

        if (line_start) begin
            line_len_d = in_x_q;
            hs_len_d   = hs_cnt_q;
            wbank_d    = ~wbank_q;
            vs_cap_d   = vsync_i;
            vb_cap_d   = vblank_i;
            en_d       = en_i;
            case (state_q)
                ST_WAIT0: state_d = ST_WAIT1;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // Output side: replay counter plus the compare results that travel alongside the RAM read.
    always_comb begin
        wrap = (line_len_q != '0) &&
               (({1'b0, out_x_q} + {{ADDR_W{1'b0}}, 1'b1}) == {1'b0, line_len_q});

        out_x_d = out_x_q;
        if (line_start || wrap) begin
            out_x_d = '0;
        end else if (out_x_q != X_MAX) begin
            out_x_d = out_x_q + X_ONE;
        end

        s1_vld_d   = (state_q == ST_RUN) && (line_len_q != '0);
        s1_first_d = (out_x_q == '0);
        s1_oob_d   = (out_x_q >= line_len_q);
        s1_hs_d    = (out_x_q < hs_len_q);
        s1_vs_d    = vs_cap_q;
        s1_vb_d    = vb_cap_q;
    end

    always_comb begin
        blank    = rd_dat[PIX_W] | s1_oob_q;
        rgb_d    = rgb_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        hblank_d = hblank_q;
        vblank_d = vblank_q;

        if (!en_q) begin
            rgb_d    = rgb_i;
            hsync_d  = hsync_i;
            vsync_d  = vsync_i;
            hblank_d = hblank_i;
            vblank_d = vblank_i;
        end else if (!s1_vld_q) begin
            rgb_d    = {PIX_W{RST_RGB}};
            hsync_d  = RST_HSYNC;
            vsync_d  = RST_VSYNC;
            hblank_d = RST_HBLANK;
            vblank_d = RST_VBLANK;
        end else begin
            rgb_d    = blank ? '0 : rd_dat[PIX_W-1:0];
            hblank_d = blank;
            hsync_d  = ~s1_hs_q;
            // Frame signals only change on output line boundaries.
            if (s1_first_q) begin
                vsync_d  = s1_vs_q;
                vblank_d = s1_vb_q;
            end
        end
    end

    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_WAIT0;
            hs_prev_q  <= 1'b0;
            in_x_q     <= '0;
            hs_cnt_q   <= '0;
            line_len_q <= '0;
            hs_len_q   <= '0;
            out_x_q    <= '0;
            wbank_q    <= 1'b0;
            vs_cap_q   <= RST_VSYNC;
            vb_cap_q   <= RST_VBLANK;
            en_q       <= 1'b1;
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_oob_q   <= 1'b1;
            s1_hs_q    <= 1'b0;
            s1_vs_q    <= RST_VSYNC;
            s1_vb_q    <= RST_VBLANK;
            rgb_q      <= {PIX_W{RST_RGB}};
            hsync_q    <= RST_HSYNC;
            vsync_q    <= RST_VSYNC;
            hblank_q   <= RST_HBLANK;
            vblank_q   <= RST_VBLANK;
        end else begin
            state_q    <= state_d;
            hs_prev_q  <= hs_prev_d;
            in_x_q     <= in_x_d;
            hs_cnt_q   <= hs_cnt_d;
            line_len_q <= line_len_d;
            hs_len_q   <= hs_len_d;
            out_x_q    <= out_x_d;
            wbank_q    <= wbank_d;
            vs_cap_q   <= vs_cap_d;
            vb_cap_q   <= vb_cap_d;
            en_q       <= en_d;
            s1_vld_q   <= s1_vld_d;
            s1_first_q <= s1_first_d;
            s1_oob_q   <= s1_oob_d;
            s1_hs_q    <= s1_hs_d;
            s1_vs_q    <= s1_vs_d;
            s1_vb_q    <= s1_vb_d;
            rgb_q      <= rgb_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            hblank_q   <= hblank_d;
            vblank_q   <= vblank_d;
        end
    end

    assign rgb_o    = rgb_q;
    assign hsync_o  = hsync_q;
    assign vsync_o  = vsync_q;
    assign hblank_o = hblank_q;
    assign vblank_o = vblank_q;

endmodule

// File: tb/tb_centipede_scandoubler.sv
// Scoreboard bench for centipede_scandoubler: expected output words are queued per cycle as video is driven.
module tb_centipede_scandoubler;

    logic       clk_12mhz = 1'b0;
    logic       reset_n   = 1'b1;
    logic       ce_pix_i  = 1'b0;
    logic       en_i      = 1'b1;
    logic [8:0] rgb_i     = '0;
    logic       hsync_i   = 1'b1;
    logic       vsync_i   = 1'b1;
    logic       hblank_i  = 1'b1;
    logic       vblank_i  = 1'b1;
    logic [8:0] rgb_o;
    logic       hsync_o, vsync_o, hblank_o, vblank_o;

    centipede_scandoubler dut (
        .clk_12mhz (clk_12mhz),
        .reset_n   (reset_n),
        .ce_pix_i  (ce_pix_i),
        .en_i      (en_i),
        .rgb_i     (rgb_i),
        .hsync_i   (hsync_i),
        .vsync_i   (vsync_i),
        .hblank_i  (hblank_i),
        .vblank_i  (vblank_i),
        .rgb_o     (rgb_o),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o),
        .hblank_o  (hblank_o),
        .vblank_o  (vblank_o)
    );

    always #5 clk_12mhz = ~clk_12mhz;

    typedef struct {
        int          cyc;
        logic [12:0] v;
    } exp_t;

    localparam logic [12:0] RST_V = {9'd0, 1'b1, 1'b1, 1'b1, 1'b1};

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    // Model of what the input side has seen: line starts, mode, and the last complete line.
    int   ls_count  = 0;
    logic en_eff    = 1'b1;
    logic prev_hs_b = 1'b0;
    logic chk_rst   = 1'b0;
    int   prev_npix = 0;
    int   prev_hsl  = 0;
    int   prev_hb   = 0;

    always @(posedge clk_12mhz) cyc <= cyc + 1;

    task automatic sd_check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    always @(negedge clk_12mhz) begin
        automatic logic [12:0] obs = {rgb_o, hsync_o, vsync_o, hblank_o, vblank_o};
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            automatic exp_t e = sb.pop_front();
            sd_check("pix", {19'd0, obs}, {19'd0, e.v});
        end else if (chk_rst && sb.size() == 0) begin
            sd_check("rst", {19'd0, obs}, {19'd0, RST_V});
        end
    end

    // Two copies of the stored line, first pixel 3 cycles after the driving slot of the line start.
    task automatic push_doubled(input logic vs, input logic vb);
        int len = (prev_npix > 511) ? 511 : prev_npix;
        int hsl = (prev_hsl > 511) ? 511 : prev_hsl;
        for (int k = 0; k < 2 * len; k++) begin
            automatic int          x = k % len;
            automatic logic        bl = (x >= prev_hb);
            automatic logic [8:0]  px = bl ? 9'd0 : 9'(x);
            automatic logic        hs = (x < hsl) ? 1'b0 : 1'b1;
            sb.push_back('{cyc + 3 + k, {px, hs, vs, bl, vb}});
        end
    endtask

    task automatic drive_cycle(input logic ce, input logic hs, input logic vs, input logic hb,
                               input logic vb, input logic [8:0] px, input logic en,
                               input int npix, input int hsl, input int hbs);
        logic ls;
        @(posedge clk_12mhz);
        #1;
        ce_pix_i = ce; hsync_i = hs; vsync_i = vs; hblank_i = hb; vblank_i = vb;
        rgb_i = px; en_i = en;
        ls = ce && prev_hs_b && !hs;
        if (!en_eff) sb.push_back('{cyc + 1, {px, hs, vs, hb, vb}});
        if (ls) begin
            if (en) begin
                while (sb.size() > 0 && sb[$].cyc >= cyc + 3) sb.delete(sb.size() - 1);
                if (ls_count >= 1) push_doubled(vs, vb);
            end else begin
                while (sb.size() > 0 && sb[$].cyc >= cyc + 2) sb.delete(sb.size() - 1);
            end
            if (ls_count >= 1) chk_rst = 1'b0;
            if (ls_count < 2) ls_count++;
            en_eff    = en;
            prev_npix = npix;
            prev_hsl  = hsl;
            prev_hb   = hbs;
        end
        if (ce) prev_hs_b = hs;
    endtask

    task automatic drive_line(input int npix, input int hsl, input int hbs,
                              input logic vs, input logic vb, input logic en);
        for (int p = 0; p < npix; p++) begin
            drive_cycle(1'b1, p >= hsl, vs, p >= hbs, vb, 9'(p), en, npix, hsl, hbs);
            drive_cycle(1'b0, p >= hsl, vs, p >= hbs, vb, 9'(p), en, npix, hsl, hbs);
        end
    endtask

    task automatic drive_idle(input int npix);
        for (int p = 0; p < npix; p++) begin
            drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 9'd0, 1'b1, 0, 0, 0);
            drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 9'd0, 1'b1, 0, 0, 0);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk_12mhz);
        #1;
        reset_n   = 1'b0;
        ce_pix_i  = 1'b0;
        sb.delete();
        chk_rst   = 1'b1;
        ls_count  = 0;
        en_eff    = 1'b1;
        prev_hs_b = 1'b0;
        repeat (3) @(posedge clk_12mhz);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int budget;
        apply_reset();
        drive_idle(8);

        // Doubling: 384-pixel ramps with a 32-pixel hsync.
        for (int i = 0; i < 3; i++) drive_line(384, 32, 384, 1'b1, 1'b0, 1'b1);

        // Blanking in the right-hand third.
        for (int i = 0; i < 2; i++) drive_line(384, 32, 256, 1'b1, 1'b0, 1'b1);

        // Frame sync: three input lines with vsync low and vblank high.
        drive_line(384, 32, 384, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive_line(384, 32, 384, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) drive_line(384, 32, 384, 1'b1, 1'b0, 1'b1);

        // Overlong line saturates the write address.
        drive_line(600, 32, 600, 1'b1, 1'b0, 1'b1);
        drive_line(384, 40, 300, 1'b1, 1'b0, 1'b1);

        // Bypass for two lines, then back to doubling.
        for (int i = 0; i < 2; i++) drive_line(384, 32, 320, 1'b0, 1'b1, 1'b0);
        drive_line(384, 16, 200, 1'b1, 1'b0, 1'b1);
        drive_line(384, 32, 384, 1'b1, 1'b0, 1'b1);

        // Mid-line reset at in_x = 100.
        drive_line(101, 32, 384, 1'b1, 1'b0, 1'b1);
        apply_reset();
        drive_idle(8);
        for (int i = 0; i < 4; i++) drive_line(384, 24, 350, 1'b1, 1'b0, 1'b1);

        budget = 0;
        while (sb.size() > 0 && budget < 1200) begin
            drive_idle(1);
            budget++;
        end
        sd_check("drain", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
